bist_misr: RTL and testbench
============================

# bist_misr

Multiple-input signature register (MISR) that compacts the response stream of the device under test during built-in self-test and compares the final signature against a golden value. It is the checking end of the BIST path: the pattern LFSR drives stimulus into the systolic array, and this block absorbs the array's result words through a valid/ready handshake. It reports done and pass/fail to the BIST controller.

## Interface
Parameters:
- NUM_BITS, 64, width of the data words and of the signature.
- CNT_BITS, 16, width of the word counter.
- POLY, 64'hD800_0000_0000_0000, feedback tap mask (bits 63, 62, 60, 59, i.e. x^64+x^63+x^61+x^60).
- TIMEOUT_CYCLES, 1024, idle-stall limit; used only when the timeout macro is defined.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle pulse that begins a compaction run.
- seed_i  in  NUM_BITS  initial signature, sampled on start.
- expected_count_i  in  CNT_BITS  number of words to absorb, sampled on start.
- golden_i  in  NUM_BITS  expected final signature, sampled in CHECK.
- valid_i  in  1  data_i holds a word.
- data_i  in  NUM_BITS  response word.
- ready_o  out  1  block accepts a word this cycle.
- busy_o  out  1  state is not IDLE and not DONE.
- signature_o  out  NUM_BITS  current signature register.
- done_o  out  1  run finished; held until the next start.
- pass_o  out  1  registered compare result; valid while done_o is high.
- timeout_o  out  1  run aborted by stall; exists only when the timeout macro is defined.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE to RUN on start_i. Seed loads into the signature, the counter clears, and count_target takes expected_count_i.
  - If expected_count_i == 0, go directly to CHECK.
- RUN: ready_o = 1.
  - An accept is valid_i & ready_o.
  - On accept: sig <= {sig[NUM_BITS-2:0], fb} ^ data_i, where fb = ^(sig & POLY); the counter increments.
  - The accept that brings the counter to count_target moves the FSM to CHECK.
- CHECK (one cycle): ready_o = 0; pass_o <= (signature_o == golden_i).
- DONE: done_o = 1 and the signature is frozen. start_i starts a new run exactly as from IDLE.
- start_i in RUN or CHECK: ignored.
- valid_i outside RUN: ignored; the signature is unchanged.
- Counter arithmetic is unsigned modulo 2^CNT_BITS. expected_count_i = 2^CNT_BITS-1 is the largest supported run.

## Timing
- Reset values: ready_o=0, busy_o=0, done_o=0, pass_o=0, timeout_o=0, signature_o=0, FSM=IDLE.
- Reset asserted mid-run returns everything to reset values immediately, without waiting for a clock edge.
- Start to ready_o high: 1 cycle.
- Last accept to done_o high: 2 cycles (CHECK, then DONE). pass_o becomes valid in the same cycle done_o rises.
- ready_o is a registered-state decode and does not depend on valid_i combinationally.
- One word is accepted per cycle at full throughput. Back-to-back accepts are required.
- In the cycle of the last accept, ready_o is still 1. It drops in the following cycle.
- signature_o updates the cycle after each accept.
- start_i in DONE: done_o and pass_o clear the next cycle.

## Configuration
- MISR_TIMEOUT_EN defined:
  - A stall counter clears on every accept and increments in every RUN cycle with no accept.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with pass_o=0 and timeout_o=1. CHECK is skipped.
  - timeout_o clears on the next start.
- MISR_TIMEOUT_EN undefined: no stall counter and no timeout_o port. RUN waits indefinitely.

## Test plan
- Reset then idle: all outputs 0 and ready_o stays 0, even with valid_i=1 and data_i=1.
- seed=0, count=1, data=1, golden=1 -> signature_o=1; done_o rises 2 cycles after the accept; pass_o=1.
- seed=0, count=3, data 1,0,0 back-to-back -> signatures 1, 2, 4; with golden=4, pass_o=1; with golden=5, pass_o=0.
- seed=64'h8000_0000_0000_0000, count=1, data=0 -> feedback bit taken, signature_o=1. Gapped valid_i (one idle cycle between words) gives the same final signature as back-to-back input.
- count=0, golden equal to seed -> CHECK immediately and pass_o=1. Reset asserted mid-run after 2 of 5 words -> all outputs 0 at once; a fresh start then completes normally.
- MISR_TIMEOUT_EN with TIMEOUT_CYCLES=8, count=4, only 2 words sent -> done_o=1, timeout_o=1 and pass_o=0 after 8 stall cycles. A repeated start clears timeout_o.

Source files
------------

// File: rtl/bist_misr.sv
//==============================================================================
// Module   : bist_misr
// Brief    : BIST response compactor (MISR) with golden-signature compare.
//            Optional stall timeout enabled by defining MISR_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bist_misr #(
    parameter int                  NUM_BITS = 64,
    parameter int                  CNT_BITS = 16,
    parameter logic [NUM_BITS-1:0] POLY     = 64'hD800_0000_0000_0000
`ifdef MISR_TIMEOUT_EN
    ,
    parameter int                  TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [NUM_BITS-1:0] seed_i,
    input  logic [CNT_BITS-1:0] expected_count_i,
    input  logic [NUM_BITS-1:0] golden_i,
    input  logic                valid_i,
    input  logic [NUM_BITS-1:0] data_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic [NUM_BITS-1:0] signature_o,
    output logic                done_o,
`ifdef MISR_TIMEOUT_EN
    output logic                timeout_o,
`endif
    output logic                pass_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] sig_q, sig_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] target_q, target_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                w_accept;
    logic                w_fb;
    logic [CNT_BITS-1:0] w_cnt_inc;

`ifdef MISR_TIMEOUT_EN
    localparam int STALL_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_BITS-1:0] stall_q, stall_d;
    logic                  timeout_q, timeout_d;
`endif

    // ready_q mirrors state==RUN, so the accept never depends on valid_i via ready.
    assign w_accept  = valid_i & ready_q;
    assign w_fb      = ^(sig_q & POLY);
    assign w_cnt_inc = cnt_q + CNT_BITS'(1);

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        done_d   = done_q;
        pass_d   = pass_q;
`ifdef MISR_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    sig_d    = seed_i;
                    cnt_d    = '0;
                    target_d = expected_count_i;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef MISR_TIMEOUT_EN
                    stall_d   = '0;
                    timeout_d = 1'b0;
`endif
                    state_d  = (expected_count_i == '0) ? S_CHECK : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    sig_d = {sig_q[NUM_BITS-2:0], w_fb} ^ data_i;
                    cnt_d = w_cnt_inc;
`ifdef MISR_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (w_cnt_inc == target_q) begin
                        state_d = S_CHECK;
                    end
                end
`ifdef MISR_TIMEOUT_EN
                else begin
                    stall_d = stall_q + STALL_BITS'(1);
                    if (stall_d == STALL_BITS'(TIMEOUT_CYCLES)) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        pass_d    = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            S_CHECK: begin
                pass_d  = (sig_q == golden_i);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_RUN);
        busy_d  = (state_d == S_RUN) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            sig_q    <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef MISR_TIMEOUT_EN
            stall_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef MISR_TIMEOUT_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign signature_o = sig_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
`ifdef MISR_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bist_misr.sv
//==============================================================================
// Module   : tb_bist_misr
// Brief    : Self-checking bench for bist_misr against a word-level MISR model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bist_misr;

    localparam logic [63:0] c_POLY = 64'hD800_0000_0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [63:0] seed_i;
    logic [15:0] expected_count_i;
    logic [63:0] golden_i;
    logic        valid_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        busy_o;
    logic [63:0] signature_o;
    logic        done_o;
    logic        pass_o;
`ifdef MISR_TIMEOUT_EN
    logic        timeout_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

`ifdef MISR_TIMEOUT_EN
    bist_misr #(.NUM_BITS(64), .CNT_BITS(16), .POLY(c_POLY), .TIMEOUT_CYCLES(8)) dut (
`else
    bist_misr #(.NUM_BITS(64), .CNT_BITS(16), .POLY(c_POLY)) dut (
`endif
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i),
        .expected_count_i(expected_count_i), .golden_i(golden_i),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o), .busy_o(busy_o),
        .signature_o(signature_o), .done_o(done_o),
`ifdef MISR_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .pass_o(pass_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: shift left, insert parity of tapped bits, then xor the word in.
    function automatic logic [63:0] misr_next(input logic [63:0] s, input logic [63:0] d);
        int taps = 0;
        for (int i = 0; i < 64; i++) if (c_POLY[i] && s[i]) taps++;
        return ((s << 1) | 64'(taps % 2)) ^ d;
    endfunction

    function automatic logic [63:0] misr_fold(input logic [63:0] seed, input logic [63:0] w[$]);
        logic [63:0] s = seed;
        foreach (w[i]) s = misr_next(s, w[i]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input logic [63:0] seed, input logic [63:0] words[$],
                       input logic [63:0] gold, input bit gapped);
        logic [63:0] exp = seed;
        golden_i         = gold;
        seed_i           = seed;
        expected_count_i = 16'(words.size());
        start_i          = 1'b1;
        step();
        start_i = 1'b0;
        chk("seed_load", signature_o, seed);
        chk("busy_run", {63'd0, busy_o}, 64'd1);
        chk("done_clr", {63'd0, done_o}, 64'd0);
        foreach (words[i]) begin
            if (gapped) begin
                valid_i = 1'b0;
                data_i  = {$urandom, $urandom};
                step();
                chk("gap_hold", signature_o, exp);
            end
            valid_i = 1'b1;
            data_i  = words[i];
            chk("ready_run", {63'd0, ready_o}, 64'd1);
            step();
            valid_i = 1'b0;
            exp     = misr_next(exp, words[i]);
            chk("sig", signature_o, exp);
        end
        chk("ready_check", {63'd0, ready_o}, 64'd0);
        chk("done_early", {63'd0, done_o}, 64'd0);
        step();
        chk("done", {63'd0, done_o}, 64'd1);
        chk("pass", {63'd0, pass_o}, {63'd0, exp == gold});
        chk("busy_done", {63'd0, busy_o}, 64'd0);
        chk("sig_final", signature_o, exp);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] s, f;
        rst_i = 1'b1; start_i = 1'b0; seed_i = '0; expected_count_i = '0;
        golden_i = '0; valid_i = 1'b0; data_i = '0;
        #12;
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_pass", {63'd0, pass_o}, 64'd0);
        chk("rst_sig", signature_o, 64'd0);
`ifdef MISR_TIMEOUT_EN
        chk("rst_timeout", {63'd0, timeout_o}, 64'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        valid_i = 1'b1; data_i = 64'd1;
        repeat (3) step();
        chk("idle_ready", {63'd0, ready_o}, 64'd0);
        chk("idle_sig", signature_o, 64'd0);
        valid_i = 1'b0;

        q = '{64'd1};
        run(64'd0, q, 64'd1, 1'b0);
        chk("one_word_sig", signature_o, 64'd1);

        q = '{64'd1, 64'd0, 64'd0};
        run(64'd0, q, 64'd4, 1'b0);
        chk("three_sig", signature_o, 64'd4);
        run(64'd0, q, 64'd5, 1'b0);
        chk("three_fail", {63'd0, pass_o}, 64'd0);

        // Signature frozen in DONE while valid_i toggles.
        valid_i = 1'b1; data_i = 64'hFFFF;
        repeat (2) step();
        valid_i = 1'b0;
        chk("done_frozen", signature_o, 64'd4);
        chk("done_hold", {63'd0, done_o}, 64'd1);

        q = '{64'd0};
        run(64'h8000_0000_0000_0000, q, 64'd1, 1'b0);
        chk("fb_sig", signature_o, 64'd1);

        q = {};
        for (int i = 0; i < 6; i++) q.push_back({$urandom, $urandom});
        f = misr_fold(64'hA5A5_0000_1234_5678, q);
        run(64'hA5A5_0000_1234_5678, q, f, 1'b0);
        chk("b2b_final", signature_o, f);
        run(64'hA5A5_0000_1234_5678, q, f, 1'b1);
        chk("gap_final", signature_o, f);

        q = {};
        run(64'hDEAD_BEEF_0BAD_F00D, q, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        chk("zero_pass", {63'd0, pass_o}, 64'd1);

        // Reset asserted between clock edges after 2 of 5 words.
        seed_i = 64'h1234; expected_count_i = 16'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        valid_i = 1'b1;
        repeat (2) begin data_i = {$urandom, $urandom}; step(); end
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("amid_ready", {63'd0, ready_o}, 64'd0);
        chk("amid_busy", {63'd0, busy_o}, 64'd0);
        chk("amid_sig", signature_o, 64'd0);
        chk("amid_done", {63'd0, done_o}, 64'd0);
        step();
        rst_i = 1'b0;
        q = '{64'd7, 64'd9};
        f = misr_fold(64'h55, q);
        run(64'h55, q, f, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 12);
            q = {};
            for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
            s = {$urandom, $urandom};
            f = misr_fold(s, q);
            if ($urandom_range(0, 1) == 1) f = f ^ (64'd1 << $urandom_range(0, 63));
            run(s, q, f, bit'($urandom_range(0, 1)));
        end

`ifdef MISR_TIMEOUT_EN
        seed_i = 64'd3; expected_count_i = 16'd4; golden_i = 64'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        valid_i = 1'b1;
        repeat (2) begin data_i = {$urandom, $urandom}; step(); end
        valid_i = 1'b0;
        repeat (7) step();
        chk("to_early", {63'd0, done_o}, 64'd0);
        step();
        chk("to_done", {63'd0, done_o}, 64'd1);
        chk("to_flag", {63'd0, timeout_o}, 64'd1);
        chk("to_pass", {63'd0, pass_o}, 64'd0);
        q = '{64'd1};
        run(64'd0, q, 64'd1, 1'b0);
        chk("to_clear", {63'd0, timeout_o}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
